// File: rtl/led_frame_buffer.sv
// Double-buffered pixel store feeding the WS2801 driver: writes land in a back buffer,
// a commit publishes it to led_rgb. Optional macro: LED_FRAME_BUFFER_AUTO_REFRESH_EN.
module led_frame_buffer #(
   parameter int LEDS         = 50,
   parameter int FREQ         = 12_500_000,
   parameter int MIN_FRAME_US = 1000,
   localparam int IW          = (LEDS > 1) ? $clog2(LEDS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [IW-1:0]        wr_idx,
   input  logic [23:0]          wr_rgb,
   input  logic                 commit,
   output logic                 busy,
   output logic                 pending,
   output logic [15:0]          frame_cnt,
   output logic [24*LEDS-1:0]   led_rgb,
   output logic                 start,
   input  logic                 done
);

   localparam longint unsigned GAP_RAW    = 64'(FREQ) * 64'(MIN_FRAME_US) / 64'd1_000_000;
   localparam longint unsigned GAP_CYCLES = (GAP_RAW < 64'd2) ? 64'd2 : GAP_RAW;
   localparam int              CW         = $clog2(GAP_CYCLES) + 1;
   localparam logic [CW-1:0]   GAP_LAST   = CW'(GAP_CYCLES - 64'd1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_GAP} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_copy;
   logic                 w_load_cnt;
   logic [CW-1:0]        r_cnt;
   logic                 r_pending;
   logic [15:0]          r_frame_cnt;
   logic [24*LEDS-1:0]   r_front;
   logic [24*LEDS-1:0]   w_back;

   // Back buffer: one register per pixel, out-of-range indices match no pixel.
   generate
      for (genvar gi = 0; gi < LEDS; gi++) begin : g_pix
         logic [23:0] r_pix;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_pix <= 24'd0;
            end else if (wr_en && (wr_idx == IW'(gi))) begin
               r_pix <= wr_rgb;
            end
         end
         assign w_back[24*gi +: 24] = r_pix;
      end
   endgenerate

`ifdef LED_FRAME_BUFFER_AUTO_REFRESH_EN
   logic [CW-1:0] r_idle_cnt;

   // Consecutive IDLE cycles with nothing to publish; any commit restarts the wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle_cnt <= '0;
      end else if ((r_state != S_IDLE) || r_pending || commit) begin
         r_idle_cnt <= '0;
      end else if (r_idle_cnt != GAP_LAST) begin
         r_idle_cnt <= r_idle_cnt + CW'(1);
      end
   end
`endif

   always_comb begin
      w_state_next = r_state;
      w_copy       = 1'b0;
      w_load_cnt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pending) begin
               w_copy       = 1'b1;
               w_load_cnt   = 1'b1;
               w_state_next = S_START;
            end
`ifdef LED_FRAME_BUFFER_AUTO_REFRESH_EN
            else if (!commit && (r_idle_cnt == GAP_LAST)) begin
               w_load_cnt   = 1'b1;
               w_state_next = S_START;
            end
`endif
         end
         S_START: w_state_next = S_BUSY;
         S_BUSY:  if (done) w_state_next = S_GAP;
         S_GAP:   if (r_cnt >= GAP_LAST) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Interval counter starts at 0 in the START cycle and saturates at the last gap cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_load_cnt) begin
         r_cnt <= '0;
      end else if (r_cnt != GAP_LAST) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= 1'b0;
      end else if (w_copy) begin
         r_pending <= 1'b0;
      end else if (commit) begin
         r_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= 16'd0;
      end else if ((r_state == S_BUSY) && done) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_front <= '0;
      end else if (w_copy) begin
         r_front <= w_back;
      end
   end

   always_comb begin
      busy  = (r_state != S_IDLE);
      start = (r_state == S_START);
   end

   assign pending   = r_pending;
   assign frame_cnt = r_frame_cnt;
   assign led_rgb   = r_front;

endmodule
